// File: rtl/axi4_mem_responder.sv
// AXI4 memory responder: one transaction at a time against an internal
// word-addressed memory. Supports FIXED/INCR/WRAP bursts, byte strobes,
// ID echo and SLVERR for out-of-range, oversized or malformed beats.
module axi4_mem_responder #(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           ID_WIDTH   = 1,
  parameter int unsigned           MEM_WORDS  = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                    clk,
  input  logic                    reset,
  // write address
  input  logic                    io_axi_aw_valid,
  output logic                    io_axi_aw_ready,
  input  logic [ADDR_WIDTH-1:0]   io_axi_aw_payload_addr,
  input  logic [ID_WIDTH-1:0]     io_axi_aw_payload_id,
  input  logic [7:0]              io_axi_aw_payload_len,
  input  logic [2:0]              io_axi_aw_payload_size,
  input  logic [1:0]              io_axi_aw_payload_burst,
  input  logic [3:0]              io_axi_aw_payload_region,
  input  logic                    io_axi_aw_payload_lock,
  input  logic [3:0]              io_axi_aw_payload_cache,
  input  logic [3:0]              io_axi_aw_payload_qos,
  input  logic [2:0]              io_axi_aw_payload_prot,
  // write data
  input  logic                    io_axi_w_valid,
  output logic                    io_axi_w_ready,
  input  logic [DATA_WIDTH-1:0]   io_axi_w_payload_data,
  input  logic [DATA_WIDTH/8-1:0] io_axi_w_payload_strb,
  input  logic                    io_axi_w_payload_last,
  // write response
  output logic                    io_axi_b_valid,
  input  logic                    io_axi_b_ready,
  output logic [ID_WIDTH-1:0]     io_axi_b_payload_id,
  output logic [1:0]              io_axi_b_payload_resp,
  // read address
  input  logic                    io_axi_ar_valid,
  output logic                    io_axi_ar_ready,
  input  logic [ADDR_WIDTH-1:0]   io_axi_ar_payload_addr,
  input  logic [ID_WIDTH-1:0]     io_axi_ar_payload_id,
  input  logic [7:0]              io_axi_ar_payload_len,
  input  logic [2:0]              io_axi_ar_payload_size,
  input  logic [1:0]              io_axi_ar_payload_burst,
  input  logic [3:0]              io_axi_ar_payload_region,
  input  logic                    io_axi_ar_payload_lock,
  input  logic [3:0]              io_axi_ar_payload_cache,
  input  logic [3:0]              io_axi_ar_payload_qos,
  input  logic [2:0]              io_axi_ar_payload_prot,
  // read data
  output logic                    io_axi_r_valid,
  input  logic                    io_axi_r_ready,
  output logic [DATA_WIDTH-1:0]   io_axi_r_payload_data,
  output logic [ID_WIDTH-1:0]     io_axi_r_payload_id,
  output logic [1:0]              io_axi_r_payload_resp,
  output logic                    io_axi_r_payload_last
);

  localparam int unsigned BYTES  = DATA_WIDTH / 8;
  localparam int unsigned LANE_W = $clog2(BYTES);
  localparam int unsigned IDX_W  = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WDATA = 2'd1;
  localparam logic [1:0] WRESP = 2'd2;
  localparam logic [1:0] RDATA = 2'd3;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

  logic [1:0]            state;
  logic                  prioWrite;
  logic                  awReady;
  logic                  arReady;
  logic [ADDR_WIDTH-1:0] curAddr;
  logic [ID_WIDTH-1:0]   idReg;
  logic [7:0]            lenReg;
  logic [2:0]            sizeReg;
  logic [1:0]            burstReg;
  logic                  burstErr;
  logic                  errFlag;
  logic [7:0]            beatCnt;
  logic                  rValid;
  logic [DATA_WIDTH-1:0] rData;
  logic [1:0]            rResp;
  logic                  rLast;

  logic [ADDR_WIDTH-1:0] wrWord;
  logic                  wrErr;
  logic                  memWe;
  logic [ADDR_WIDTH-1:0] rdAddr;
  logic [ADDR_WIDTH-1:0] rdWord;
  logic                  rdErr;
  logic                  awWins;
  logic                  arWins;
  logic                  unusedSinks;

  function automatic logic [ADDR_WIDTH-1:0] wordIndex(input logic [ADDR_WIDTH-1:0] a);
    return (a - BASE_ADDR) >> LANE_W;
  endfunction

  function automatic logic beatErr(input logic [ADDR_WIDTH-1:0] a, input logic [2:0] sz);
    logic [ADDR_WIDTH-1:0] idx;
    idx = wordIndex(a);
    return (sz > 3'(LANE_W)) || (a < BASE_ADDR) || (idx >= ADDR_WIDTH'(MEM_WORDS));
  endfunction

  function automatic logic wrapBad(input logic [1:0] bu, input logic [7:0] len);
    return (bu == BURST_WRAP) &&
           !((len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15));
  endfunction

  // A WRAP with an illegal length advances like INCR; its beats are flagged via burstErr.
  function automatic logic [ADDR_WIDTH-1:0] nextAddr(input logic [ADDR_WIDTH-1:0] a,
                                                     input logic [2:0] sz,
                                                     input logic [7:0] len,
                                                     input logic [1:0] bu);
    logic [ADDR_WIDTH-1:0] step;
    logic [ADDR_WIDTH-1:0] sum;
    logic [ADDR_WIDTH-1:0] wrapMask;
    step     = ADDR_WIDTH'(1) << sz;
    sum      = a + step;
    wrapMask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << sz) - ADDR_WIDTH'(1);
    if (bu == BURST_FIXED)
      return a;
    else if (bu == BURST_WRAP && !wrapBad(bu, len))
      return (a & ~wrapMask) | (sum & wrapMask);
    else
      return sum;
  endfunction

  // Beat address/error decode for the write port and the read prefetch.
  always_comb begin
    wrWord = wordIndex(curAddr);
    wrErr  = beatErr(curAddr, sizeReg) || burstErr;
    memWe  = (state == WDATA) && io_axi_w_valid && !wrErr;
    rdAddr = '0;
    rdErr  = 1'b0;
    if (state == IDLE) begin
      rdAddr = io_axi_ar_payload_addr;
      rdErr  = beatErr(rdAddr, io_axi_ar_payload_size) ||
               wrapBad(io_axi_ar_payload_burst, io_axi_ar_payload_len);
    end else begin
      rdAddr = nextAddr(curAddr, sizeReg, lenReg, burstReg);
      rdErr  = beatErr(rdAddr, sizeReg) || burstErr;
    end
    rdWord = wordIndex(rdAddr);
    awWins = io_axi_aw_valid && (!io_axi_ar_valid || prioWrite);
    arWins = io_axi_ar_valid && !awWins;
  end

  // Byte-lane write port; memory contents survive reset.
  always_ff @(posedge clk) begin
    if (memWe) begin
      for (int unsigned b = 0; b < BYTES; b++) begin
        if (io_axi_w_payload_strb[b])
          mem[wrWord[IDX_W-1:0]][b*8 +: 8] <= io_axi_w_payload_data[b*8 +: 8];
      end
    end
  end

  // Transaction FSM: arbitration, burst sequencing and registered R channel.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      prioWrite <= 1'b1;
      awReady   <= 1'b0;
      arReady   <= 1'b0;
      curAddr   <= '0;
      idReg     <= '0;
      lenReg    <= '0;
      sizeReg   <= '0;
      burstReg  <= '0;
      burstErr  <= 1'b0;
      errFlag   <= 1'b0;
      beatCnt   <= '0;
      rValid    <= 1'b0;
      rData     <= '0;
      rResp     <= RESP_OKAY;
      rLast     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (awReady && io_axi_aw_valid) begin
            awReady   <= 1'b0;
            prioWrite <= ~prioWrite;
            curAddr   <= io_axi_aw_payload_addr;
            idReg     <= io_axi_aw_payload_id;
            lenReg    <= io_axi_aw_payload_len;
            sizeReg   <= io_axi_aw_payload_size;
            burstReg  <= io_axi_aw_payload_burst;
            burstErr  <= wrapBad(io_axi_aw_payload_burst, io_axi_aw_payload_len);
            errFlag   <= 1'b0;
            beatCnt   <= '0;
            state     <= WDATA;
          end else if (arReady && io_axi_ar_valid) begin
            arReady   <= 1'b0;
            prioWrite <= ~prioWrite;
            curAddr   <= io_axi_ar_payload_addr;
            idReg     <= io_axi_ar_payload_id;
            lenReg    <= io_axi_ar_payload_len;
            sizeReg   <= io_axi_ar_payload_size;
            burstReg  <= io_axi_ar_payload_burst;
            burstErr  <= wrapBad(io_axi_ar_payload_burst, io_axi_ar_payload_len);
            errFlag   <= 1'b0;
            beatCnt   <= '0;
            rValid    <= 1'b1;
            rData     <= rdErr ? '0 : mem[rdWord[IDX_W-1:0]];
            rResp     <= rdErr ? RESP_SLVERR : RESP_OKAY;
            rLast     <= (io_axi_ar_payload_len == 8'd0);
            state     <= RDATA;
          end else begin
            awReady <= awWins;
            arReady <= arWins;
          end
        end
        WDATA: begin
          if (io_axi_w_valid) begin
            errFlag <= errFlag | wrErr | (io_axi_w_payload_last != (beatCnt == lenReg));
            if (beatCnt == lenReg) begin
              state <= WRESP;
            end else begin
              beatCnt <= beatCnt + 8'd1;
              curAddr <= nextAddr(curAddr, sizeReg, lenReg, burstReg);
            end
          end
        end
        WRESP: begin
          if (io_axi_b_ready)
            state <= IDLE;
        end
        RDATA: begin
          if (io_axi_r_ready) begin
            if (rLast) begin
              rValid <= 1'b0;
              rData  <= '0;
              rResp  <= RESP_OKAY;
              rLast  <= 1'b0;
              state  <= IDLE;
            end else begin
              beatCnt <= beatCnt + 8'd1;
              curAddr <= rdAddr;
              rData   <= rdErr ? '0 : mem[rdWord[IDX_W-1:0]];
              rResp   <= rdErr ? RESP_SLVERR : RESP_OKAY;
              rLast   <= ((beatCnt + 8'd1) == lenReg);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign io_axi_aw_ready       = awReady;
  assign io_axi_ar_ready       = arReady;
  assign io_axi_w_ready        = (state == WDATA);
  assign io_axi_b_valid        = (state == WRESP);
  assign io_axi_b_payload_id   = (state == WRESP) ? idReg : '0;
  assign io_axi_b_payload_resp = ((state == WRESP) && errFlag) ? RESP_SLVERR : RESP_OKAY;
  assign io_axi_r_valid        = rValid;
  assign io_axi_r_payload_data = rData;
  assign io_axi_r_payload_id   = rValid ? idReg : '0;
  assign io_axi_r_payload_resp = rResp;
  assign io_axi_r_payload_last = rLast;

  assign unusedSinks = ^{io_axi_aw_payload_region, io_axi_aw_payload_lock,
                         io_axi_aw_payload_cache, io_axi_aw_payload_qos,
                         io_axi_aw_payload_prot, io_axi_ar_payload_region,
                         io_axi_ar_payload_lock, io_axi_ar_payload_cache,
                         io_axi_ar_payload_qos, io_axi_ar_payload_prot,
                         wrWord[ADDR_WIDTH-1:IDX_W], rdWord[ADDR_WIDTH-1:IDX_W]};

endmodule

// File: tb/tb_axi4_mem_responder.sv
// Directed bench for axi4_mem_responder: single/INCR/WRAP bursts, strobes,
// error responses, arbitration, R stall stability and mid-burst reset.
module tb_axi4_mem_responder;

  localparam int TMO = 50;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        reset;
  logic        awValid, awReady;
  logic [31:0] awAddr;
  logic [0:0]  awId;
  logic [7:0]  awLen;
  logic [2:0]  awSize;
  logic [1:0]  awBurst;
  logic        wValid, wReady;
  logic [31:0] wData;
  logic [3:0]  wStrb;
  logic        wLast;
  logic        bValid, bReady;
  logic [0:0]  bId;
  logic [1:0]  bResp;
  logic        arValid, arReady;
  logic [31:0] arAddr;
  logic [0:0]  arId;
  logic [7:0]  arLen;
  logic [2:0]  arSize;
  logic [1:0]  arBurst;
  logic        rValid, rReady;
  logic [31:0] rData;
  logic [0:0]  rId;
  logic [1:0]  rResp;
  logic        rLast;

  axi4_mem_responder #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(1), .MEM_WORDS(1024), .BASE_ADDR(32'h0)
  ) dut (
    .clk(clk), .reset(reset),
    .io_axi_aw_valid(awValid), .io_axi_aw_ready(awReady),
    .io_axi_aw_payload_addr(awAddr), .io_axi_aw_payload_id(awId),
    .io_axi_aw_payload_len(awLen), .io_axi_aw_payload_size(awSize),
    .io_axi_aw_payload_burst(awBurst), .io_axi_aw_payload_region(4'd0),
    .io_axi_aw_payload_lock(1'b0), .io_axi_aw_payload_cache(4'd0),
    .io_axi_aw_payload_qos(4'd0), .io_axi_aw_payload_prot(3'd0),
    .io_axi_w_valid(wValid), .io_axi_w_ready(wReady),
    .io_axi_w_payload_data(wData), .io_axi_w_payload_strb(wStrb),
    .io_axi_w_payload_last(wLast),
    .io_axi_b_valid(bValid), .io_axi_b_ready(bReady),
    .io_axi_b_payload_id(bId), .io_axi_b_payload_resp(bResp),
    .io_axi_ar_valid(arValid), .io_axi_ar_ready(arReady),
    .io_axi_ar_payload_addr(arAddr), .io_axi_ar_payload_id(arId),
    .io_axi_ar_payload_len(arLen), .io_axi_ar_payload_size(arSize),
    .io_axi_ar_payload_burst(arBurst), .io_axi_ar_payload_region(4'd0),
    .io_axi_ar_payload_lock(1'b0), .io_axi_ar_payload_cache(4'd0),
    .io_axi_ar_payload_qos(4'd0), .io_axi_ar_payload_prot(3'd0),
    .io_axi_r_valid(rValid), .io_axi_r_ready(rReady),
    .io_axi_r_payload_data(rData), .io_axi_r_payload_id(rId),
    .io_axi_r_payload_resp(rResp), .io_axi_r_payload_last(rLast)
  );

  logic [31:0] wq [16];
  logic [31:0] rq [16];
  logic        rl [16];
  logic [1:0]  rr [16];
  logic        rid [16];
  int          rc [16];
  logic        bIdGot;
  logic [1:0]  bRespGot;
  int          arCyc;

  // ---------------- transaction drivers ----------------
  task automatic doReset();
    reset = 1'b1;
    awValid = 0; awAddr = '0; awId = '0; awLen = '0; awSize = '0; awBurst = '0;
    wValid = 0; wData = '0; wStrb = '0; wLast = 0; bReady = 0;
    arValid = 0; arAddr = '0; arId = '0; arLen = '0; arSize = '0; arBurst = '0;
    rReady = 0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic awStart(input logic [31:0] a, input logic i, input logic [7:0] l,
                         input logic [2:0] s, input logic [1:0] bu);
    awAddr = a; awId = i; awLen = l; awSize = s; awBurst = bu; awValid = 1'b1;
  endtask

  task automatic arStart(input logic [31:0] a, input logic i, input logic [7:0] l,
                         input logic [2:0] s, input logic [1:0] bu);
    arAddr = a; arId = i; arLen = l; arSize = s; arBurst = bu; arValid = 1'b1;
  endtask

  task automatic awWait();
    int n = 0;
    while (!awReady && n < TMO) begin @(posedge clk); #1; n++; end
    if (!awReady) begin
      errors++; checks++;
      $display("FAIL aw_handshake got=timeout exp=ready");
    end else begin
      @(posedge clk); #1;
    end
    awValid = 1'b0;
  endtask

  task automatic arWait();
    int n = 0;
    while (!arReady && n < TMO) begin @(posedge clk); #1; n++; end
    if (!arReady) begin
      errors++; checks++;
      $display("FAIL ar_handshake got=timeout exp=ready");
    end else begin
      @(posedge clk); #1;
    end
    arCyc = cyc;
    arValid = 1'b0;
  endtask

  task automatic waitAnyReady();
    int n = 0;
    while (!awReady && !arReady && n < TMO) begin @(posedge clk); #1; n++; end
  endtask

  task automatic wBurst(input int beats, input logic [3:0] s, input int lastAt);
    for (int i = 0; i < beats; i++) begin
      int n = 0;
      wData = wq[i]; wStrb = s; wLast = (i == lastAt); wValid = 1'b1;
      while (!wReady && n < TMO) begin @(posedge clk); #1; n++; end
      if (!wReady) begin
        errors++; checks++;
        $display("FAIL w_handshake beat=%0d got=timeout exp=ready", i);
        break;
      end
      @(posedge clk); #1;
    end
    wValid = 1'b0; wLast = 1'b0;
  endtask

  task automatic bWait();
    int n = 0;
    bReady = 1'b1;
    while (!bValid && n < TMO) begin @(posedge clk); #1; n++; end
    if (!bValid) begin
      errors++; checks++;
      $display("FAIL b_handshake got=timeout exp=valid");
      bIdGot = 1'bx; bRespGot = 2'bxx;
    end else begin
      bIdGot = bId; bRespGot = bResp;
      @(posedge clk); #1;
    end
    bReady = 1'b0;
  endtask

  task automatic rCollect(input int beats);
    for (int i = 0; i < 16; i++) begin rq[i] = 'x; rl[i] = 1'bx; rr[i] = 2'bxx; rid[i] = 1'bx; rc[i] = -1; end
    rReady = 1'b1;
    for (int i = 0; i < beats; i++) begin
      int n = 0;
      while (!rValid && n < TMO) begin @(posedge clk); #1; n++; end
      if (!rValid) begin
        errors++; checks++;
        $display("FAIL r_handshake beat=%0d got=timeout exp=valid", i);
        break;
      end
      rq[i] = rData; rl[i] = rLast; rr[i] = rResp; rid[i] = rId; rc[i] = cyc;
      @(posedge clk); #1;
    end
    rReady = 1'b0;
  endtask

  task automatic doWrite(input logic [31:0] a, input logic i, input logic [7:0] l,
                         input logic [2:0] s, input logic [1:0] bu, input logic [3:0] st,
                         input int lastAt);
    awStart(a, i, l, s, bu);
    awWait();
    wBurst(int'(l) + 1, st, lastAt);
    bWait();
  endtask

  task automatic doRead(input logic [31:0] a, input logic i, input logic [7:0] l,
                        input logic [2:0] s, input logic [1:0] bu);
    arStart(a, i, l, s, bu);
    arWait();
    rCollect(int'(l) + 1);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    #1;
    checks++;
    if ({awReady, arReady, wReady, bValid, rValid, rLast} !== 6'b0) begin
      errors++; $display("FAIL reset_ctrl got=%b exp=000000", {awReady, arReady, wReady, bValid, rValid, rLast});
    end
    checks++;
    if (rData !== 32'h0) begin errors++; $display("FAIL reset_rdata got=%h exp=00000000", rData); end
    checks++;
    if ({rResp, bResp, bId, rId} !== 6'b0) begin
      errors++; $display("FAIL reset_payload got=%b exp=000000", {rResp, bResp, bId, rId});
    end
  endtask

  task automatic test_single();
    wq[0] = 32'hDEADBEEF;
    doWrite(32'h10, 1'b1, 8'd0, 3'd2, 2'b01, 4'hF, 0);
    checks++;
    if (bRespGot !== 2'b00) begin errors++; $display("FAIL single_bresp got=%b exp=00", bRespGot); end
    checks++;
    if (bIdGot !== 1'b1) begin errors++; $display("FAIL single_bid got=%b exp=1", bIdGot); end
    doRead(32'h10, 1'b1, 8'd0, 3'd2, 2'b01);
    checks++;
    if (rq[0] !== 32'hDEADBEEF) begin errors++; $display("FAIL single_rdata got=%h exp=deadbeef", rq[0]); end
    checks++;
    if ({rl[0], rr[0], rid[0]} !== 4'b1001) begin
      errors++; $display("FAIL single_rlast_resp_id got=%b exp=1001", {rl[0], rr[0], rid[0]});
    end
    checks++;
    if (rc[0] !== arCyc) begin errors++; $display("FAIL single_rlatency got=%0d exp=%0d", rc[0], arCyc); end
  endtask

  task automatic test_incr();
    for (int i = 0; i < 4; i++) wq[i] = 32'(i + 1);
    doWrite(32'h100, 1'b0, 8'd3, 3'd2, 2'b01, 4'hF, 3);
    checks++;
    if (bRespGot !== 2'b00) begin errors++; $display("FAIL incr_bresp got=%b exp=00", bRespGot); end
    doRead(32'h100, 1'b0, 8'd3, 3'd2, 2'b01);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rq[i] !== 32'(i + 1)) begin errors++; $display("FAIL incr_rdata beat=%0d got=%h exp=%h", i, rq[i], 32'(i + 1)); end
      checks++;
      if (rl[i] !== (i == 3)) begin errors++; $display("FAIL incr_rlast beat=%0d got=%b exp=%b", i, rl[i], (i == 3)); end
      checks++;
      if (rc[i] !== rc[0] + i) begin errors++; $display("FAIL incr_b2b beat=%0d got=%0d exp=%0d", i, rc[i], rc[0] + i); end
    end
  endtask

  task automatic test_wrap();
    logic [31:0] expv [4];
    wq[0] = 32'hA0A0_0001; wq[1] = 32'hA0A0_0002; wq[2] = 32'hA0A0_0003; wq[3] = 32'hA0A0_0004;
    doWrite(32'h0C, 1'b0, 8'd3, 3'd2, 2'b10, 4'hF, 3);
    checks++;
    if (bRespGot !== 2'b00) begin errors++; $display("FAIL wrap_bresp got=%b exp=00", bRespGot); end
    // beats landed at 0x0C, 0x00, 0x04, 0x08
    expv[0] = 32'hA0A0_0002; expv[1] = 32'hA0A0_0003; expv[2] = 32'hA0A0_0004; expv[3] = 32'hA0A0_0001;
    doRead(32'h00, 1'b0, 8'd3, 3'd2, 2'b01);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rq[i] !== expv[i]) begin errors++; $display("FAIL wrap_incr_read beat=%0d got=%h exp=%h", i, rq[i], expv[i]); end
    end
    doRead(32'h0C, 1'b0, 8'd3, 3'd2, 2'b10);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rq[i] !== wq[i]) begin errors++; $display("FAIL wrap_wrap_read beat=%0d got=%h exp=%h", i, rq[i], wq[i]); end
    end
    checks++;
    if (rl[3] !== 1'b1) begin errors++; $display("FAIL wrap_rlast got=%b exp=1", rl[3]); end
  endtask

  task automatic test_strobe();
    wq[0] = 32'h11223344;
    doWrite(32'h40, 1'b0, 8'd0, 3'd2, 2'b01, 4'hF, 0);
    wq[0] = 32'hAABBCCDD;
    doWrite(32'h40, 1'b0, 8'd0, 3'd2, 2'b01, 4'h5, 0);
    doRead(32'h40, 1'b0, 8'd0, 3'd2, 2'b01);
    checks++;
    if (rq[0] !== 32'h11BB33DD) begin errors++; $display("FAIL strobe_merge got=%h exp=11bb33dd", rq[0]); end
  endtask

  task automatic test_errors();
    doRead(32'h1000, 1'b1, 8'd0, 3'd2, 2'b01);
    checks++;
    if ({rq[0], rr[0], rl[0]} !== {32'h0, 2'b10, 1'b1}) begin
      errors++; $display("FAIL err_oor_read got=%h/%b/%b exp=00000000/10/1", rq[0], rr[0], rl[0]);
    end
    doRead(32'hFFC, 1'b1, 8'd0, 3'd2, 2'b01);
    checks++;
    if (rr[0] !== 2'b00) begin errors++; $display("FAIL err_lastword_resp got=%b exp=00", rr[0]); end
    wq[0] = 32'hFFFFFFFF;
    doWrite(32'h100, 1'b1, 8'd0, 3'd3, 2'b01, 4'hF, 0);
    checks++;
    if ({bRespGot, bIdGot} !== 3'b101) begin errors++; $display("FAIL err_size_b got=%b exp=101", {bRespGot, bIdGot}); end
    doRead(32'h100, 1'b0, 8'd0, 3'd2, 2'b01);
    checks++;
    if (rq[0] !== 32'h1) begin errors++; $display("FAIL err_size_nowrite got=%h exp=00000001", rq[0]); end
    for (int i = 0; i < 4; i++) wq[i] = 32'h5500 + 32'(i);
    doWrite(32'h200, 1'b0, 8'd3, 3'd2, 2'b01, 4'hF, 1);
    checks++;
    if (bRespGot !== 2'b10) begin errors++; $display("FAIL err_wlast_b got=%b exp=10", bRespGot); end
  endtask

  task automatic test_arbitration();
    doReset();
    wq[0] = 32'h33;
    awStart(32'h300, 1'b1, 8'd0, 3'd2, 2'b01);
    arStart(32'h100, 1'b0, 8'd0, 3'd2, 2'b01);
    waitAnyReady();
    checks++;
    if ({awReady, arReady} !== 2'b10) begin errors++; $display("FAIL arb_first got=%b exp=10", {awReady, arReady}); end
    awWait();
    wBurst(1, 4'hF, 0);
    bWait();
    wq[0] = 32'h44;
    awStart(32'h304, 1'b1, 8'd0, 3'd2, 2'b01);
    waitAnyReady();
    checks++;
    if ({awReady, arReady} !== 2'b01) begin errors++; $display("FAIL arb_second got=%b exp=01", {awReady, arReady}); end
    arWait();
    rCollect(1);
    checks++;
    if (rq[0] !== 32'h1) begin errors++; $display("FAIL arb_rdata got=%h exp=00000001", rq[0]); end
    awWait();
    wBurst(1, 4'hF, 0);
    bWait();
    checks++;
    if (bRespGot !== 2'b00) begin errors++; $display("FAIL arb_bresp got=%b exp=00", bRespGot); end
    doRead(32'h300, 1'b0, 8'd1, 3'd2, 2'b01);
    checks++;
    if ({rq[0], rq[1]} !== {32'h33, 32'h44}) begin
      errors++; $display("FAIL arb_readback got=%h %h exp=00000033 00000044", rq[0], rq[1]);
    end
  endtask

  task automatic test_stall();
    logic [15:0] pat;
    logic [36:0] held;
    logic        prevStall;
    int          beat;
    int          n;
    pat = 16'b1011_0010_0110_1100;
    beat = 0; n = 0; prevStall = 1'b0; held = '0;
    arStart(32'h100, 1'b1, 8'd3, 3'd2, 2'b01);
    arWait();
    while (beat < 4 && n < 60) begin
      rReady = pat[n % 16];
      if (prevStall) begin
        checks++;
        if ({rValid, rData, rResp, rLast, rId} !== held) begin
          errors++; $display("FAIL stall_hold got=%h exp=%h", {rValid, rData, rResp, rLast, rId}, held);
        end
      end
      if (rValid && rReady) begin
        checks++;
        if ({rData, rLast} !== {32'(beat + 1), (beat == 3)}) begin
          errors++; $display("FAIL stall_beat beat=%0d got=%h/%b exp=%h/%b", beat, rData, rLast, 32'(beat + 1), (beat == 3));
        end
        beat++;
        prevStall = 1'b0;
      end else if (rValid) begin
        held = {rValid, rData, rResp, rLast, rId};
        prevStall = 1'b1;
      end else begin
        prevStall = 1'b0;
      end
      @(posedge clk); #1;
      n++;
    end
    rReady = 1'b0;
    checks++;
    if (beat !== 4) begin errors++; $display("FAIL stall_complete got=%0d exp=4", beat); end
  endtask

  task automatic test_reset_mid_read();
    int seen;
    arStart(32'h100, 1'b0, 8'd7, 3'd2, 2'b01);
    arWait();
    checks++;
    if (rValid !== 1'b1) begin errors++; $display("FAIL midrst_pre got=%b exp=1", rValid); end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({rValid, awReady, arReady} !== 3'b000) begin
      errors++; $display("FAIL midrst_async got=%b exp=000", {rValid, awReady, arReady});
    end
    @(posedge clk); #1 reset = 1'b0;
    rReady = 1'b1;
    seen = 0;
    repeat (4) begin @(posedge clk); #1; if (rValid) seen++; end
    rReady = 1'b0;
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL midrst_no_r got=%0d exp=0", seen); end
    wq[0] = 32'h12345678;
    doWrite(32'h500, 1'b1, 8'd0, 3'd2, 2'b01, 4'hF, 0);
    checks++;
    if ({bRespGot, bIdGot} !== 3'b001) begin errors++; $display("FAIL midrst_write got=%b exp=001", {bRespGot, bIdGot}); end
    doRead(32'h500, 1'b1, 8'd0, 3'd2, 2'b01);
    checks++;
    if ({rq[0], rr[0], rl[0]} !== {32'h12345678, 2'b00, 1'b1}) begin
      errors++; $display("FAIL midrst_read got=%h/%b/%b exp=12345678/00/1", rq[0], rr[0], rl[0]);
    end
    doRead(32'h10, 1'b0, 8'd0, 3'd2, 2'b01);
    checks++;
    if (rq[0] !== 32'hDEADBEEF) begin errors++; $display("FAIL midrst_mem_kept got=%h exp=deadbeef", rq[0]); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    doReset();
    reset = 1'b1;
    test_reset();
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1;
    test_single();
    test_incr();
    test_wrap();
    test_strobe();
    test_errors();
    test_stall();
    test_arbitration();
    test_reset_mid_read();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axi4_mem_responder.md
Name: axi4_mem_responder

Overview:
- AXI4 slave (responder) backed by an internal word-addressed memory.
- Answers the burst read and write traffic that the AXI4 DPI master generates in the simulation testbench.
- Also serves as the standard memory target for future initiator blocks.
- Services one transaction at a time with full burst support (FIXED/INCR/WRAP), byte strobes, ID echo and SLVERR signalling.

Parameters:
- ADDR_WIDTH, 32, AR/AW address width.
- DATA_WIDTH, 32, R/W data width; power of two, >= 8.
- ID_WIDTH, 1, AXI ID width.
- MEM_WORDS, 1024, memory depth in DATA_WIDTH words.
- BASE_ADDR, 0, byte address of word 0.

Ports:
- clk  in  1  clock
- reset  in  1  reset
- io_axi_aw_valid/ready  in/out  1  write-address handshake
- io_axi_aw_payload_addr  in  ADDR_WIDTH  burst start byte address
- io_axi_aw_payload_id  in  ID_WIDTH  write ID
- io_axi_aw_payload_len  in  8  beats-1
- io_axi_aw_payload_size  in  3  log2 bytes/beat
- io_axi_aw_payload_burst  in  2  00 FIXED, 01 INCR, 10 WRAP
- io_axi_aw_payload_region/lock/cache/qos/prot  in  4/1/4/4/3  accepted, ignored
- io_axi_w_valid/ready  in/out  1  write-data handshake
- io_axi_w_payload_data  in  DATA_WIDTH  write data
- io_axi_w_payload_strb  in  DATA_WIDTH/8  byte enables
- io_axi_w_payload_last  in  1  final write beat
- io_axi_b_valid/ready  out/in  1  response handshake
- io_axi_b_payload_id  out  ID_WIDTH  echoed AW ID
- io_axi_b_payload_resp  out  2  00 OKAY, 10 SLVERR
- io_axi_ar_valid/ready, io_axi_ar_payload_addr/id/len/size/burst, region/lock/cache/qos/prot  as AW
- io_axi_r_valid/ready  out/in  1  read-data handshake
- io_axi_r_payload_data  out  DATA_WIDTH  read data
- io_axi_r_payload_id  out  ID_WIDTH  echoed AR ID
- io_axi_r_payload_resp  out  2  per-beat response
- io_axi_r_payload_last  out  1  final read beat

Behaviour:
- Clock and reset: single clock clk; reset is asynchronous, active-high.
- Reset values: all valid/ready outputs 0; payload outputs 0; FSM enters IDLE; priority flag set to "write next". Memory contents are not reset.
- FSM states: IDLE, WDATA, WRESP, RDATA.

IDLE:
- aw_ready/ar_ready are registered; exactly one is raised, for the channel with a valid request.
- If both are valid, the priority flag picks the winner; the flag toggles after every accepted request (round-robin).
- On handshake: latch addr/id/len/size/burst; clear the error flag and beat counter.
- An AW win goes to WDATA; an AR win goes to RDATA.

Per-beat address rules:
- FIXED: address unchanged.
- INCR: address += 2^size.
- WRAP: wrap boundary = (len+1)*2^size; len must be 1/3/7/15, otherwise treated as INCR with SLVERR.
- Word index = (addr - BASE_ADDR) >> log2(DATA_WIDTH/8).

Beat errors (SLVERR):
- size > log2(DATA_WIDTH/8), or
- addr < BASE_ADDR, or
- word index >= MEM_WORDS.

WDATA:
- w_ready = 1; one beat is written per handshake.
- Each byte lane is written only where strb = 1; erroring beats are dropped.
- After beat len+1 the FSM goes to WRESP.
- A w_last value that disagrees with the beat counter sets the error flag. The counter alone ends the burst; there is no w_last-driven early exit.

WRESP:
- b_valid = 1; resp = SLVERR if any beat errored, else OKAY; id = latched ID.
- b_valid, id and resp hold until b_ready; the FSM then returns to IDLE.

RDATA:
- r_valid rises the cycle after the AR handshake.
- Data is registered from memory; beats go out back-to-back while r_ready = 1.
- Erroring beats return data 0 with SLVERR; other beats return OKAY.
- last = 1 on beat len+1; the FSM goes to IDLE after that handshake.
- While r_ready = 0, all R outputs hold stable.

Concurrency and reset:
- No overlap: AR and AW are not accepted outside IDLE.
- Reset mid-burst aborts immediately: outputs go to reset values, and no B or R is issued for the aborted transaction.

Test Plan:
- Single write then read: AW addr 0x10 len 0, W 0xDEADBEEF strb 0xF, then AR 0x10 -> B OKAY id echoed; R 0xDEADBEEF, last=1, OKAY.
- INCR len 3 write 0x100..0x10C with data 1,2,3,4, then INCR read -> R beats 1,2,3,4, last only on beat 4; with r_ready held 1 the beats arrive on consecutive cycles.
- WRAP len 3 size 2 start 0x0C -> beats address 0x0C, 0x00, 0x04, 0x08; readback confirms the order.
- Strobe: write 0xAABBCCDD strb 0x5 over existing 0x11223344 -> read returns 0x11BB33DD.
- Errors: AR at word MEM_WORDS -> R data 0, SLVERR. AW with size 3 -> B SLVERR, memory unchanged. w_last asserted on beat 2 of len 3 -> B SLVERR.
- Arbitration and robustness:
  - AR and AW valid in the same cycle twice -> first AW accepted, then AR.
  - r_ready toggled randomly -> payload stable while stalled.
  - reset asserted mid-RDATA -> r_valid drops asynchronously; the next transaction completes normally.
